// File: rtl/combo_lock_ctrl.sv
// Keypad combination lock: code entry with error lockout, idle auto-relock and
// atomic code reprogramming. Single clock domain, synchronous active-high reset.
module combo_lock_ctrl #(
    parameter int                            NUM_BTN      = 4,
    parameter int                            CODE_LEN     = 3,
    parameter int                            MAX_ERR      = 3,
    parameter int                            LOCK_SECS    = 10,
    parameter int                            RELOCK_SECS  = 30,
    parameter int                            CLK_HZ       = 50_000_000,
    parameter logic [CODE_LEN*NUM_BTN-1:0]   DEFAULT_CODE = 12'hBDE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTN-1:0]   btn_n,
    input  logic                 ms,
    input  logic                 lock,
    output logic                 unlocked,
    output logic                 prog_mode,
    output logic                 locked_out,
    output logic [CODE_LEN-1:0]  leds_ok,
    output logic [MAX_ERR-1:0]   leds_err,
    output logic [LOCK_SECS-1:0] leds_secs
);

    localparam int CODE_W   = CODE_LEN * NUM_BTN;
    localparam int MAX_SECS = (LOCK_SECS > RELOCK_SECS) ? LOCK_SECS : RELOCK_SECS;
    localparam int SEC_W    = $clog2(MAX_SECS + 1);
    localparam int PRESC_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int IDX_W    = $clog2(CODE_LEN + 1);
    localparam int ERR_W    = $clog2(MAX_ERR + 1);

    localparam logic [NUM_BTN-1:0] BTN_IDLE    = '1;
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]   SEC_SAT     = SEC_W'(MAX_SECS);
    localparam logic [SEC_W-1:0]   LOCK_LAST   = SEC_W'(LOCK_SECS - 1);
    localparam logic [SEC_W-1:0]   RELOCK_LAST = SEC_W'(RELOCK_SECS - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(CODE_LEN - 1);
    localparam logic [ERR_W-1:0]   ERR_LIMIT   = ERR_W'(MAX_ERR);

    localparam logic [1:0] ST_ENTRY   = 2'd0;
    localparam logic [1:0] ST_OPEN    = 2'd1;
    localparam logic [1:0] ST_PROG    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    logic [1:0]         r_state;
    logic [NUM_BTN-1:0] r_btn_prev;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_pidx;
    logic [ERR_W-1:0]   r_err;
    logic [CODE_W-1:0]  r_code;
    logic [CODE_W-1:0]  r_shadow;
    logic [PRESC_W-1:0] r_presc;
    logic [SEC_W-1:0]   r_secs;

    logic [1:0]         w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [IDX_W-1:0]   w_pidx_nxt;
    logic [ERR_W-1:0]   w_err_nxt;
    logic [CODE_W-1:0]  w_code_nxt;
    logic [CODE_W-1:0]  w_shadow_nxt;
    logic [PRESC_W-1:0] w_presc_nxt;
    logic [SEC_W-1:0]   w_secs_nxt;
    logic               w_idle_restart;

    logic [NUM_BTN-1:0] w_btn_low;
    logic               w_press;
    logic               w_one_hot;
    logic [NUM_BTN-1:0] w_cur_digit;
    logic               w_timer_run;
    logic               w_tick;
    logic [IDX_W-1:0]   w_ok_cnt;

    // A press is the single cycle where buttons leave the all-released state.
    assign w_btn_low   = ~btn_n;
    assign w_press     = (r_btn_prev == BTN_IDLE) && (btn_n != BTN_IDLE);
    assign w_one_hot   = (w_btn_low != '0) && ((w_btn_low & (w_btn_low - NUM_BTN'(1))) == '0);
    assign w_cur_digit = r_code[int'(r_idx)*NUM_BTN +: NUM_BTN];

    assign w_timer_run = (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);
    assign w_tick      = w_timer_run && (r_presc == PRESC_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a hold value first, so no path infers a latch.
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_pidx_nxt     = r_pidx;
        w_err_nxt      = r_err;
        w_code_nxt     = r_code;
        w_shadow_nxt   = r_shadow;
        w_idle_restart = 1'b0;

        case (r_state)
            ST_ENTRY: begin
                if (w_press) begin
                    if (w_one_hot && (btn_n == w_cur_digit)) begin
                        if (r_idx == IDX_LAST) begin
                            w_state_nxt = ST_OPEN;
                            w_idx_nxt   = '0;
                            w_err_nxt   = '0;
                        end else begin
                            w_idx_nxt = r_idx + IDX_W'(1);
                        end
                    end else begin
                        w_idx_nxt = '0;
                        w_err_nxt = r_err + ERR_W'(1);
                        if (w_err_nxt == ERR_LIMIT) begin
                            w_state_nxt = ST_LOCKOUT;
                        end
                    end
                end
            end

            ST_OPEN: begin
                if (lock) begin
                    w_state_nxt = ST_ENTRY;
                end else if (ms) begin
                    w_state_nxt = ST_PROG;
                    w_pidx_nxt  = '0;
                end else if (w_press) begin
                    // Activity beats a coincident timeout tick.
                    w_idle_restart = 1'b1;
                end else if (w_tick && (r_secs == RELOCK_LAST)) begin
                    w_state_nxt = ST_ENTRY;
                end
            end

            ST_PROG: begin
                if (lock || (w_press && !w_one_hot)) begin
                    w_state_nxt = ST_OPEN;
                end else if (w_press) begin
                    w_shadow_nxt[int'(r_pidx)*NUM_BTN +: NUM_BTN] = btn_n;
                    if (r_pidx == IDX_LAST) begin
                        w_code_nxt  = w_shadow_nxt;
                        w_pidx_nxt  = '0;
                        w_state_nxt = ST_ENTRY;
                    end else begin
                        w_pidx_nxt = r_pidx + IDX_W'(1);
                    end
                end
            end

            ST_LOCKOUT: begin
                if (w_tick && (r_secs == LOCK_LAST)) begin
                    w_state_nxt = ST_ENTRY;
                    w_err_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end

            default: w_state_nxt = ST_ENTRY;
        endcase
    end

    // The timer counts only while staying in a timed state; any state change clears it.
    always_comb begin
        w_presc_nxt = '0;
        w_secs_nxt  = '0;
        if (w_timer_run && (w_state_nxt == r_state) && !w_idle_restart) begin
            if (w_tick) begin
                w_secs_nxt = (r_secs == SEC_SAT) ? r_secs : r_secs + SEC_W'(1);
            end else begin
                w_presc_nxt = r_presc + PRESC_W'(1);
                w_secs_nxt  = r_secs;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ENTRY;
            r_btn_prev <= BTN_IDLE;
            r_idx      <= '0;
            r_pidx     <= '0;
            r_err      <= '0;
            r_code     <= DEFAULT_CODE;
            r_presc    <= '0;
            r_secs     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_btn_prev <= btn_n;
            r_idx      <= w_idx_nxt;
            r_pidx     <= w_pidx_nxt;
            r_err      <= w_err_nxt;
            r_code     <= w_code_nxt;
            r_presc    <= w_presc_nxt;
            r_secs     <= w_secs_nxt;
        end
    end

    // NOTE: the shadow code needs no reset; pidx restarts at 0 and every slot is rewritten before a commit.
    always_ff @(posedge clk) begin
        r_shadow <= w_shadow_nxt;
    end

    assign unlocked   = (r_state == ST_OPEN);
    assign prog_mode  = (r_state == ST_PROG);
    assign locked_out = (r_state == ST_LOCKOUT);

    always_comb begin
        w_ok_cnt = '0;
        if (r_state == ST_ENTRY) begin
            w_ok_cnt = r_idx;
        end else if (r_state == ST_PROG) begin
            w_ok_cnt = r_pidx;
        end
        for (int k = 0; k < CODE_LEN; k++) begin
            leds_ok[k] = (int'(w_ok_cnt) > k);
        end
        for (int k = 0; k < MAX_ERR; k++) begin
            leds_err[k] = (int'(r_err) > k);
        end
        for (int k = 0; k < LOCK_SECS; k++) begin
            leds_secs[k] = locked_out && (int'(r_secs) > k);
        end
    end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Bench for combo_lock_ctrl: directed and random button traffic, with every cycle's
// outputs predicted by a rule-level model and compared through a scoreboard queue.
module tb_combo_lock_ctrl;

    localparam int NB = 4;
    localparam int CL = 3;
    localparam int ME = 3;
    localparam int LS = 10;
    localparam int RS = 2;
    localparam int HZ = 4;
    localparam logic [CL*NB-1:0] DEF_CODE = 12'hBDE;
    localparam logic [NB-1:0]    NONE     = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_n;
    logic          ms;
    logic          lock;
    logic          unlocked;
    logic          prog_mode;
    logic          locked_out;
    logic [CL-1:0] leds_ok;
    logic [ME-1:0] leds_err;
    logic [LS-1:0] leds_secs;

    combo_lock_ctrl #(
        .NUM_BTN(NB), .CODE_LEN(CL), .MAX_ERR(ME), .LOCK_SECS(LS),
        .RELOCK_SECS(RS), .CLK_HZ(HZ), .DEFAULT_CODE(DEF_CODE)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .ms(ms), .lock(lock),
        .unlocked(unlocked), .prog_mode(prog_mode), .locked_out(locked_out),
        .leds_ok(leds_ok), .leds_err(leds_err), .leds_secs(leds_secs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          unl;
        logic          prg;
        logic          lko;
        logic [CL-1:0] ok;
        logic [ME-1:0] err;
        logic [LS-1:0] secs;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT shows against the oldest due prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check("unlocked",   32'(unlocked),   32'(e.unl));
            check("prog_mode",  32'(prog_mode),  32'(e.prg));
            check("locked_out", 32'(locked_out), 32'(e.lko));
            check("leds_ok",    32'(leds_ok),    32'(e.ok));
            check("leds_err",   32'(leds_err),   32'(e.err));
            check("leds_secs",  32'(leds_secs),  32'(e.secs));
        end
    end

    // ---------------- reference model (rule level) ----------------
    typedef enum {M_ENTRY, M_OPEN, M_PROG, M_LOCKOUT} mode_e;

    mode_e         m_mode;
    int            m_idx;
    int            m_err;
    int            m_pcnt;
    int            m_elapsed;
    logic [NB-1:0] m_prev;
    logic [NB-1:0] m_code[CL];
    logic [NB-1:0] m_shadow[$];

    function automatic int zeros(input logic [NB-1:0] b);
        int z = 0;
        for (int i = 0; i < NB; i++) if (!b[i]) z++;
        return z;
    endfunction

    function automatic logic [31:0] therm(input int n);
        return (n <= 0) ? 32'd0 : (32'd1 << n) - 32'd1;
    endfunction

    task automatic model_reset();
        logic [CL*NB-1:0] dc;
        dc        = DEF_CODE;
        m_mode    = M_ENTRY;
        m_idx     = 0;
        m_err     = 0;
        m_pcnt    = 0;
        m_elapsed = 0;
        m_prev    = NONE;
        m_shadow.delete();
        for (int i = 0; i < CL; i++) m_code[i] = dc[i*NB +: NB];
    endtask

    task automatic model_step(input logic [NB-1:0] b, input logic m, input logic l, input logic r);
        bit press;
        bit valid;
        if (r) begin
            model_reset();
            return;
        end
        press  = (m_prev == NONE) && (b != NONE);
        valid  = press && (zeros(b) == 1);
        m_prev = b;
        case (m_mode)
            M_ENTRY: begin
                if (press) begin
                    if (valid && b == m_code[m_idx]) begin
                        m_idx++;
                        if (m_idx == CL) begin
                            m_mode = M_OPEN; m_idx = 0; m_err = 0; m_elapsed = 0;
                        end
                    end else begin
                        m_idx = 0;
                        m_err++;
                        if (m_err == ME) begin
                            m_mode = M_LOCKOUT; m_elapsed = 0;
                        end
                    end
                end
            end
            M_OPEN: begin
                if (l) m_mode = M_ENTRY;
                else if (m) begin
                    m_mode = M_PROG; m_pcnt = 0; m_shadow.delete();
                end
                else if (press) m_elapsed = 0;
                else if (m_elapsed + 1 == RS * HZ) m_mode = M_ENTRY;
                else m_elapsed++;
            end
            M_PROG: begin
                if (l || (press && !valid)) begin
                    m_mode = M_OPEN; m_elapsed = 0;
                end else if (press) begin
                    m_shadow.push_back(b);
                    m_pcnt++;
                    if (m_pcnt == CL) begin
                        for (int i = 0; i < CL; i++) m_code[i] = m_shadow[i];
                        m_mode = M_ENTRY;
                        m_pcnt = 0;
                    end
                end
            end
            M_LOCKOUT: begin
                if (m_elapsed + 1 == LS * HZ) begin
                    m_mode = M_ENTRY; m_err = 0; m_idx = 0;
                end else m_elapsed++;
            end
        endcase
    endtask

    task automatic push_expected();
        exp_t e;
        e.due  = cyc + 1;
        e.unl  = (m_mode == M_OPEN);
        e.prg  = (m_mode == M_PROG);
        e.lko  = (m_mode == M_LOCKOUT);
        e.ok   = CL'(therm(m_mode == M_ENTRY ? m_idx : (m_mode == M_PROG ? m_pcnt : 0)));
        e.err  = ME'(therm(m_err));
        e.secs = (m_mode == M_LOCKOUT) ? LS'(therm(m_elapsed / HZ)) : '0;
        sb.push_back(e);
    endtask

    // ---------------- stimulus ----------------
    task automatic cycle(input logic [NB-1:0] b, input logic m, input logic l, input logic r);
        btn_n = b; ms = m; lock = l; rst = r;
        model_step(b, m, l, r);
        push_expected();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(NONE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press(input logic [NB-1:0] b);
        cycle(b, 1'b0, 1'b0, 1'b0);
        cycle(NONE, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [NB-1:0] last;
        logic [NB-1:0] b;
        int            sel;

        model_reset();
        cycle(NONE, 1'b0, 1'b0, 1'b1);
        cycle(NONE, 1'b0, 1'b0, 1'b1);
        idle(1);

        // Default code unlocks, then lock relocks.
        press(4'hE); press(4'hD); press(4'hB); idle(2);
        cycle(NONE, 1'b0, 1'b1, 1'b0); idle(1);

        // Wrong digit resets idx and counts an error; a correct code clears it.
        press(4'hE); press(4'h7);
        press(4'hE); press(4'hD); press(4'hB);
        cycle(NONE, 1'b0, 1'b1, 1'b0);

        // Lockout: presses ignored, seconds fill, a button held through exit makes no event.
        press(4'h7); press(4'h7); press(4'h7);
        press(4'hE); press(4'hD); idle(3);
        repeat (40) cycle(4'hE, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Reprogram to 7,7,E; old first digit now fails, new code unlocks.
        press(4'hE); press(4'hD); press(4'hB);
        cycle(NONE, 1'b1, 1'b0, 1'b0);
        press(4'h7); press(4'h7); press(4'hE); idle(1);
        press(4'hE);
        press(4'h7); press(4'h7); press(4'hE); idle(1);

        // Multi-bit press in PROG aborts; code kept.
        cycle(NONE, 1'b1, 1'b0, 1'b0);
        press(4'hC); idle(1);
        cycle(NONE, 1'b0, 1'b1, 1'b0);
        press(4'h7); press(4'h7); press(4'hE);

        // Idle relock.
        idle(10);

        // ms in ENTRY ignored; held button is a single event.
        cycle(NONE, 1'b1, 1'b0, 1'b0);
        repeat (5) cycle(4'h7, 1'b0, 1'b0, 1'b0);
        idle(1);
        press(4'h7); press(4'hE);

        // Press in the timeout cycle keeps the lock open, then it relocks later.
        idle(6);
        cycle(4'hB, 1'b0, 1'b0, 1'b0);
        idle(3);
        idle(10);

        // lock aborts PROG; reset mid-PROG restores the default code.
        press(4'h7); press(4'h7); press(4'hE);
        cycle(NONE, 1'b1, 1'b0, 1'b0);
        press(4'hD);
        cycle(NONE, 1'b0, 1'b1, 1'b0);
        cycle(NONE, 1'b1, 1'b0, 1'b0);
        press(4'hD);
        cycle(NONE, 1'b0, 1'b0, 1'b1);
        idle(1);
        press(4'hE); press(4'hD); press(4'hB); idle(1);
        cycle(NONE, 1'b0, 1'b1, 1'b0);

        // Random traffic, biased toward the next correct digit so unlocks happen.
        last = NONE;
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 11));
            if (sel <= 5) b = NONE;
            else if (sel <= 7) b = (m_mode == M_ENTRY) ? m_code[m_idx] : ~(NB'(1) << $urandom_range(0, NB - 1));
            else if (sel == 8) b = ~(NB'(1) << $urandom_range(0, NB - 1));
            else if (sel == 9) b = NB'($urandom);
            else b = last;
            cycle(b, ($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 599) == 0));
            last = b;
        end

        idle(2);
        repeat (3) @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Parametrised keypad lock controller that generalises the single-code safecrack FSM to any button count, code length, error limit and lockout time. It adds press-edge detection, idle auto-relock and atomic code reprogramming. It sits between the debounced button inputs and the board LEDs and unlock driver, and runs entirely in the `clk` domain.

## Interface
- `NUM_BTN`, 4: number of buttons; the code alphabet.
- `CODE_LEN`, 3: digits per code.
- `MAX_ERR`, 3: wrong codes allowed before lockout.
- `LOCK_SECS`, 10: lockout duration in seconds.
- `RELOCK_SECS`, 30: idle time in OPEN before automatic relock.
- `CLK_HZ`, 50_000_000: clock cycles per one-second tick.
- `DEFAULT_CODE`, 12'hBDE: reset code, `CODE_LEN*NUM_BTN` bits. Digit i is `[i*NUM_BTN +: NUM_BTN]`, active-low one-hot.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `btn_n` in NUM_BTN: buttons, active-low; all-ones means none pressed. Already synchronised and debounced upstream.
- `ms` in 1: code-change request, level.
- `lock` in 1: immediate relock request, level.
- `unlocked` out 1: high in OPEN only.
- `prog_mode` out 1: high in PROG only.
- `locked_out` out 1: high in LOCKOUT only.
- `leds_ok` out CODE_LEN: thermometer of digits accepted (ENTRY) or captured (PROG).
- `leds_err` out MAX_ERR: thermometer of the error count.
- `leds_secs` out LOCK_SECS: thermometer of lockout seconds elapsed.

## Operation
- **Press event:** registered `btn_prev` equals all-ones and `btn_n` does not. Only that cycle's `btn_n` value is used. Holding a button produces one event.
- **Valid digit:** exactly one bit of `btn_n` low. A multi-bit-low press is an invalid digit.
- **States:** ENTRY, OPEN, PROG, LOCKOUT. All transitions are registered; the state changes on the edge after the causing event.
- **ENTRY**, index idx:
  - Press matching `code[idx]`: idx+1.
  - Press on the last digit: go to OPEN, clear idx and err.
  - Wrong or invalid press: idx←0 and err+1. If the new err equals MAX_ERR, go to LOCKOUT.
- **OPEN:**
  - `lock`=1: go to ENTRY. `lock` has priority over `ms`.
  - Else `ms`=1: go to PROG and clear the shadow index.
  - Any press restarts the idle timer.
  - RELOCK_SECS ticks without a press: go to ENTRY.
- **PROG:**
  - Each valid press is stored in `shadow[pidx]` and pidx increments.
  - After CODE_LEN presses, `shadow` is copied to `code` in one cycle and the block goes to ENTRY.
  - An invalid press or `lock`=1 aborts: go to OPEN with the code unchanged.
- **LOCKOUT:**
  - All presses are ignored; edge tracking continues, so a button held at exit yields no event.
  - After LOCK_SECS ticks: go to ENTRY with err←0 and idx←0.
- **Tick prescaler:**
  - Counts 0..CLK_HZ-1 and pulses `tick` on the wrap.
  - Runs only in OPEN and LOCKOUT; cleared on entry to either.
  - Second counter width is `$clog2(max(LOCK_SECS,RELOCK_SECS)+1)` and saturates.
- **Simultaneous events:**
  - A press and an idle-timeout tick in the same cycle in OPEN: the press wins and the block stays OPEN.
  - `ms` arriving in ENTRY or LOCKOUT is ignored.
  - `rst` mid-PROG discards the shadow and restores `DEFAULT_CODE`.
- **Outputs:** `leds_ok` shows idx in ENTRY and pidx in PROG, and is 0 elsewhere. `leds_secs` is 0 outside LOCKOUT.

## Timing
- **Reset:** state ENTRY, `code`=`DEFAULT_CODE`, idx, pidx, err, seconds and prescaler all 0, `btn_prev` all-ones. All outputs are 0.
- **Unlock:** `unlocked` rises one cycle after the final correct press cycle.
- **Counter updates:** `leds_ok` and `leds_err` update one cycle after the press.
- **Lockout entry:** `locked_out` rises one cycle after the MAX_ERR-th wrong press.
- **Lockout LEDs:** `leds_secs[k]` rises the cycle after tick k+1.
- **Lockout exit:** `locked_out` falls the cycle after tick LOCK_SECS, i.e. LOCK_SECS*CLK_HZ+1 cycles after entry.
- **Relock:** `unlocked` falls one cycle after `lock`=1 is sampled, or after idle tick RELOCK_SECS.
- **New code:** it is active for compare from the first ENTRY cycle after commit.

## Test plan
- **Default code:** CLK_HZ=4. Press 1110, 1101, 1011 with releases between → `leds_ok` goes 001, 011, then `unlocked`=1 one cycle after the third press, and `leds_err`=000.
- **Wrong digit:** press 1110, then 0111 → idx returns to 0, `leds_ok`=000, `leds_err`=001. A following correct sequence unlocks and clears `leds_err`.
- **Lockout:** 3 wrong presses → `locked_out`=1. Presses during lockout change nothing. `leds_secs` fills one bit per 4 cycles. Exit after 41 cycles, with `leds_err`=000.
- **Reprogram:** unlock, raise `ms`, press 0111, 0111, 1110 → `prog_mode` falls and the block goes to ENTRY. The old code now fails and the new code unlocks.
- **PROG abort:** in PROG, press 1100 (multi-bit) → back to OPEN, and the old code still unlocks.
- **Idle relock and holds:** RELOCK_SECS=2, CLK_HZ=4. Idle in OPEN → `unlocked` falls after 9 cycles. A held button produces a single event, and a press in the timeout cycle keeps the block OPEN.
